// File: rtl/ctrl_frame_tx.sv
// Framed UART transmitter for the analog-control link: SYNC, N_CH snapshot bytes, CSUM.
// 8N1, LSB first, idle high; every bit is held DIV = fCLK/BAUD clock cycles.
module ctrl_frame_tx #(
    parameter int          fCLK = 50_000_000,
    parameter int          BAUD = 115_200,
    parameter int          N_CH = 8,
    parameter logic [7:0]  SYNC = 8'hA5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [8*N_CH-1:0]   ch_data,
    input  logic                send,
    output logic                busy,
    output logic                frame_done,
    output logic                CTRL_TX
);

    localparam int DIV    = fCLK / BAUD;
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BYTE_W = $clog2(N_CH + 2);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_CH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [8*N_CH-1:0]   snap_q, snap_d;
    logic [7:0]          csum_q, csum_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tick;
    logic                frame_end;
    logic                accept;
    logic [7:0]          cur_byte;

    assign tick      = (cnt_q == CNT_MAX);
    assign frame_end = (state_q == S_STOP) && tick && (byte_q == BYTE_LAST);
    // The transmitter is free again at the edge that ends the final stop bit,
    // so a request sampled there chains the next frame with no idle cycle.
    assign accept    = send && (!busy_q || frame_end);

    always_comb begin
        csum_d = 8'd0;
        for (int i = 0; i < N_CH; i++) begin
            csum_d = csum_d + snap_q[8*i +: 8];
        end
    end

    always_comb begin
        cur_byte = SYNC;
        if (byte_q == BYTE_LAST) begin
            cur_byte = csum_q;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (byte_q == BYTE_W'(i + 1)) begin
                    cur_byte = snap_q[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap_d  = snap_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_START: begin
                if (tick) begin
                    cnt_d   = '0;
                    bit_d   = 4'd1;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                // bit_q = k while data bit k-1 is on the line
                if (tick) begin
                    cnt_d = '0;
                    if (bit_q == 4'd8) begin
                        bit_d   = 4'd9;
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = cur_byte[bit_q[2:0]];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    bit_d = 4'd0;
                    if (byte_q == BYTE_LAST) begin
                        byte_d  = '0;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (accept) begin
            snap_d  = ch_data;
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = 4'd0;
            byte_d  = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            byte_q  <= '0;
            snap_q  <= '0;
            csum_q  <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            csum_q  <= csum_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign CTRL_TX    = tx_q;

endmodule
